// File: rtl/alarm_scheduler.sv
// Alarm sequencer: NUM_SLOTS programmable alarm times compared once per second,
// driving the buzzer through a ring / snooze / dismiss state machine.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no event; waiting for an enabled slot to match on sec_tick
// ST_RING    | buzzer on; counting down RING_SECS ticks to auto-timeout
// ST_SNOOZE  | buzzer off; counting down SNOOZE_SECS ticks, then rings again

module alarm_scheduler #(
   parameter int NUM_SLOTS   = 4,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic                 newclk,
   input  logic                 reset,
   input  logic                 sec_tick,
   input  logic [10:0]          hour,
   input  logic [10:0]          minute,
   input  logic [10:0]          second,
   input  logic                 cfg_we,
   input  logic [1:0]           cfg_slot,
   input  logic [10:0]          cfg_hour,
   input  logic [10:0]          cfg_minute,
   input  logic [10:0]          cfg_second,
   input  logic                 cfg_en,
   input  logic                 middle,
   input  logic                 down,
   output logic                 ring,
   output logic [1:0]           alarm_mode,
   output logic [1:0]           active_slot,
   output logic [1:0]           snooze_cnt,
   output logic [NUM_SLOTS-1:0] slot_en
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RING   = 2'd1;
   localparam logic [1:0] ST_SNOOZE = 2'd2;

   localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
   localparam int CNT_W    = $clog2(MAX_SECS + 1);

   localparam logic [CNT_W-1:0] RING_LOAD    = CNT_W'(RING_SECS);
   localparam logic [CNT_W-1:0] SNOOZE_LOAD  = CNT_W'(SNOOZE_SECS);
   localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
   localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZE);

   logic [10:0]          slot_hour   [NUM_SLOTS];
   logic [10:0]          slot_minute [NUM_SLOTS];
   logic [10:0]          slot_second [NUM_SLOTS];

   logic [NUM_SLOTS-1:0] slot_match;
   logic                 any_match;
   logic [1:0]           match_idx;

   logic                 middle_q;
   logic                 down_q;
   logic                 dismiss_edge;
   logic                 snooze_edge;

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [CNT_W-1:0]     timer_q;
   logic [CNT_W-1:0]     timer_d;
   logic [1:0]           slot_d;
   logic [1:0]           cnt_d;
   logic                 timer_done;
   logic                 cancel;

   always_ff @(posedge newclk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_hour[i]   <= '0;
            slot_minute[i] <= '0;
            slot_second[i] <= '0;
         end
         slot_en <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cfg_slot == 2'(i)) begin
               slot_hour[i]   <= cfg_hour;
               slot_minute[i] <= cfg_minute;
               slot_second[i] <= cfg_second;
               slot_en[i]     <= cfg_en;
            end
         end
      end
   end

   // Compare reads the registered slot contents, so a same-cycle write is not seen yet.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_match[i] = slot_en[i] &&
                         (slot_hour[i]   == hour)   &&
                         (slot_minute[i] == minute) &&
                         (slot_second[i] == second);
      end
   end

   always_comb begin
      any_match = |slot_match;
      match_idx = 2'd0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_match[i]) begin
            match_idx = 2'(i);
         end
      end
   end

   // Loaded with the live level in reset so a held button yields no edge afterwards.
   always_ff @(posedge newclk) begin
      if (reset) begin
         middle_q <= middle;
         down_q   <= down;
      end else begin
         middle_q <= middle;
         down_q   <= down;
      end
   end

   assign dismiss_edge = middle & ~middle_q;
   assign snooze_edge  = down & ~down_q;

   assign timer_done = sec_tick && (timer_q == TIMER_ONE);
   assign cancel     = cfg_we && !cfg_en && (cfg_slot == active_slot) && (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      slot_d  = active_slot;
      cnt_d   = snooze_cnt;
      case (state_q)
         ST_IDLE: begin
            if (sec_tick && any_match) begin
               state_d = ST_RING;
               timer_d = RING_LOAD;
               slot_d  = match_idx;
               cnt_d   = 2'd0;
            end
         end
         ST_RING: begin
            if (dismiss_edge || cancel) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (snooze_edge && (snooze_cnt < SNOOZE_LIMIT)) begin
               state_d = ST_SNOOZE;
               timer_d = SNOOZE_LOAD;
               cnt_d   = snooze_cnt + 2'd1;
            end else if (timer_done) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (sec_tick) begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         ST_SNOOZE: begin
            if (dismiss_edge || cancel) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (timer_done) begin
               state_d = ST_RING;
               timer_d = RING_LOAD;
            end else if (sec_tick) begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge newclk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         active_slot <= 2'd0;
         snooze_cnt  <= 2'd0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         active_slot <= slot_d;
         snooze_cnt  <= cnt_d;
      end
   end

   assign ring       = (state_q == ST_RING);
   assign alarm_mode = state_q;

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Sequences the clock's alarm function: holds NUM_SLOTS programmable alarm times, compares them against the running time once per second, and drives the ring output through a ring/snooze/dismiss state machine. Sits between the timekeeping counter (hour/minute/second plus a one-second tick) and the buzzer/LED driver. Button inputs are the board's debounced push-buttons; configuration writes come from the time-setting UI.

## Interface
Parameters:
- NUM_SLOTS, 4, number of alarm slots (1..4; slot index is 2 bits)
- RING_SECS, 60, seconds an alarm rings before auto-timeout
- SNOOZE_SECS, 300, snooze length in seconds
- MAX_SNOOZE, 3, snoozes allowed per alarm event

Ports:
- newclk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse; hour/minute/second already hold the new time in this cycle
- hour, minute, second  in  11 each  current time
- cfg_we  in  1  write strobe for slot config
- cfg_slot  in  2  slot written
- cfg_hour, cfg_minute, cfg_second  in  11 each  alarm time to store
- cfg_en  in  1  enable bit to store
- middle  in  1  dismiss button (level; rising edge detected internally)
- down  in  1  snooze button (level; rising edge detected internally)
- ring  out  1  buzzer drive
- alarm_mode  out  2  state: 0 IDLE, 1 RING, 2 SNOOZE
- active_slot  out  2  slot that triggered the current event
- snooze_cnt  out  2  snoozes used in the current event
- slot_en  out  NUM_SLOTS  stored enable bits

## Operation
- Slot storage: cfg_we writes all four fields of cfg_slot in one cycle; cfg_slot >= NUM_SLOTS ignored. Full 11-bit equality compare; no range checking.
- Match: on a sec_tick cycle, slot i matches if slot_en[i] and stored h/m/s == hour/minute/second. Lowest matching index wins.
- States:
  - IDLE: ring=0. Any match on sec_tick -> RING; active_slot=winner, snooze_cnt=0, ring counter=0.
  - RING: ring=1. Counts sec_ticks. Dismiss edge -> IDLE. Snooze edge with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1, snooze counter=0; snooze edge at MAX_SNOOZE ignored. RING_SECS-th tick counted -> IDLE.
  - SNOOZE: ring=0. Counts sec_ticks. Dismiss edge -> IDLE. SNOOZE_SECS-th tick -> RING, ring counter=0, same active_slot.
- Matches while in RING/SNOOZE are discarded (no queuing).
- Simultaneous dismiss and snooze edges: dismiss wins.
- Simultaneous timeout tick and button edge: button wins.
- Config write to active_slot with cfg_en=0 while in RING/SNOOZE: event cancelled -> IDLE next cycle. Write with cfg_en=1 does not affect the running event.
- Write and match on the same cycle: compare uses pre-write contents.
- Edge detectors: previous-level registers for middle/down; a button held across reset does not produce an edge after reset releases.

## Timing
- Reset: all slots cleared (time 0, disabled), slot_en=0, ring=0, alarm_mode=0, active_slot=0, snooze_cnt=0, counters 0, edge registers loaded with current button levels.
- Match latency: ring and alarm_mode=1 one cycle after the matching sec_tick cycle.
- Button latency: button rises in cycle N -> state/ring change visible at N+1.
- Timeout: entering RING at cycle T, ring drops one cycle after the RING_SECS-th sec_tick seen after T.
- Counters sized for max(RING_SECS, SNOOZE_SECS); no wrap possible within a state.
- Config write visible to the compare on the cycle after cfg_we.

## Test plan
- Write slot 1 = 07:30:00 enabled; step time to 07:30:00 with sec_tick -> ring=1, alarm_mode=1, active_slot=1 next cycle; 60 ticks later ring=0, alarm_mode=0.
- Slots 0 and 2 both 06:00:00 -> active_slot=0; rising edge on middle -> IDLE next cycle, ring=0.
- Ringing, press down 3 times, each snooze running 300 ticks -> snooze_cnt 1,2,3, ring returns each time; 4th down press ignored, ring stays 1.
- Middle and down rise the same cycle during RING -> IDLE, snooze_cnt unchanged.
- During SNOOZE, write active slot with cfg_en=0 -> IDLE next cycle; no ring at snooze expiry.
- Assert reset mid-RING -> next cycle ring=0, alarm_mode=0, slot_en=0; held button produces no action after release of reset.
